// File: rtl/mult_sched_pkg.sv
// Shared constants and helpers for the multiplier scheduler.
// Provides:
//   FracGuard  - integer bits kept above the binary point (Q2.x result format)
//   frac_shift - right shift that rescales a full product back to Q2.(w-2)
//   id_width   - requester-index width, never below one bit
//   sat_pos    - most positive w-bit signed value (zero-extended to 64 bits)
//   sat_neg    - most negative w-bit signed value (low w bits significant)
package mult_sched_pkg;

  localparam int unsigned FracGuard = 2;

  function automatic int unsigned frac_shift(int unsigned w);
    return w - FracGuard;
  endfunction

  function automatic int unsigned id_width(int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic logic [63:0] sat_pos(int unsigned w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_neg(int unsigned w);
    return ~sat_pos(w);
  endfunction

endpackage

// File: rtl/mult_core.sv
// Stage 2 of the scheduler: registered signed multiply with fixed-point rescale.
// The full 2*BITSIZE product is shifted right by BITSIZE-2 (Q2.(BITSIZE-2)).
// Build option: define MULT_SCHEDULER_SATURATE_EN to clamp overflowing results;
// otherwise overflow wraps by truncation.
// Ports:
//   clk, reset            - clock, asynchronous active-high reset
//   in_valid/in_a/in_b/in_id - stage-1 entry
//   out_valid/out_id/out_data - registered result (the scheduler response)
module mult_core
  import mult_sched_pkg::*;
#(
  parameter int unsigned BITSIZE = 16,
  parameter int unsigned IdWidth = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [BITSIZE-1:0] in_a,
  input  logic [BITSIZE-1:0] in_b,
  input  logic [IdWidth-1:0] in_id,
  output logic               out_valid,
  output logic [IdWidth-1:0] out_id,
  output logic [BITSIZE-1:0] out_data
);

  localparam int unsigned ProdW = 2 * BITSIZE;
  localparam int unsigned Shift = frac_shift(BITSIZE);

  logic signed [BITSIZE-1:0] a_s, b_s;
  logic signed [ProdW-1:0]   product;
  logic [BITSIZE-1:0]        scaled;
  logic [BITSIZE-1:0]        result;

  logic               valid_q;
  logic [IdWidth-1:0] id_q;
  logic [BITSIZE-1:0] data_q;

  assign a_s     = in_a;
  assign b_s     = in_b;
  assign product = ProdW'(a_s) * ProdW'(b_s);
  assign scaled  = product[Shift +: BITSIZE];

  // Fraction bits below the kept window are intentionally dropped.
  logic unused_frac;
  assign unused_frac = ^product[Shift-1:0];

`ifdef MULT_SCHEDULER_SATURATE_EN
  localparam logic [63:0] SatPos64 = sat_pos(BITSIZE);
  localparam logic [63:0] SatNeg64 = sat_neg(BITSIZE);
  localparam logic [BITSIZE-1:0] SatPos = SatPos64[BITSIZE-1:0];
  localparam logic [BITSIZE-1:0] SatNeg = SatNeg64[BITSIZE-1:0];

  logic [2:0] top_bits;
  logic       overflow;

  // The three top product bits must agree for the Q2 result to be representable.
  assign top_bits = product[ProdW-1 -: 3];
  assign overflow = !((&top_bits) || !(|top_bits));

  always_comb begin
    result = scaled;
    if (overflow) begin
      result = product[ProdW-1] ? SatNeg : SatPos;
    end
  end
`else
  logic unused_top;
  assign unused_top = ^product[ProdW-1 -: 2];
  assign result     = scaled;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      id_q    <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        id_q   <= in_id;
        data_q <= result;
      end
    end
  end

  assign out_valid = valid_q;
  assign out_id    = id_q;
  assign out_data  = data_q;

endmodule

// File: rtl/mult_scheduler.sv
// Round-robin scheduler sharing one pipelined fixed-point multiplier among
// NREQ requesters. Stage 1 (operand capture) lives here; stage 2 is mult_core.
// Response appears two cycles after the transfer cycle; one transfer per cycle.
// Build option: MULT_SCHEDULER_SATURATE_EN enables result saturation in mult_core.
// Ports:
//   clk, reset        - clock, asynchronous active-high reset
//   req_valid/ready   - per-requester handshake (ready is a one-hot grant)
//   req_a, req_b      - packed signed operands, requester i at [i*BITSIZE +: BITSIZE]
//   rsp_valid/id/data - result pulse, owning requester, scaled product
//   busy              - any pipeline stage occupied
module mult_scheduler
  import mult_sched_pkg::*;
#(
  parameter int unsigned BITSIZE = 16,
  parameter int unsigned NREQ    = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NREQ-1:0]             req_valid,
  output logic [NREQ-1:0]             req_ready,
  input  logic [NREQ*BITSIZE-1:0]     req_a,
  input  logic [NREQ*BITSIZE-1:0]     req_b,
  output logic                        rsp_valid,
  output logic [id_width(NREQ)-1:0]   rsp_id,
  output logic [BITSIZE-1:0]          rsp_data,
  output logic                        busy
);

  localparam int unsigned IdW = id_width(NREQ);

  logic [IdW-1:0] ptr_q, ptr_d;
  logic           grant_any;
  logic [IdW-1:0] grant_id;
  logic           xfer;
  int unsigned    idx;

  logic               s1_valid_q;
  logic [BITSIZE-1:0] s1_a_q, s1_b_q;
  logic [IdW-1:0]     s1_id_q;

  // Search upward from the pointer with wrap; first valid requester wins.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    idx       = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (32'(ptr_q) + k) % NREQ;
      if (!grant_any && req_valid[idx]) begin
        grant_any = 1'b1;
        grant_id  = IdW'(idx);
      end
    end
  end

  assign xfer = grant_any && !reset;

  always_comb begin
    req_ready = '0;
    if (xfer) begin
      req_ready[grant_id] = 1'b1;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (xfer) begin
      ptr_d = (32'(grant_id) == NREQ - 1) ? '0 : IdW'(32'(grant_id) + 1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_id_q    <= '0;
    end else begin
      ptr_q      <= ptr_d;
      s1_valid_q <= xfer;
      if (xfer) begin
        s1_a_q  <= req_a[grant_id * BITSIZE +: BITSIZE];
        s1_b_q  <= req_b[grant_id * BITSIZE +: BITSIZE];
        s1_id_q <= grant_id;
      end
    end
  end

  mult_core #(
    .BITSIZE (BITSIZE),
    .IdWidth (IdW)
  ) u_core (
    .clk      (clk),
    .reset    (reset),
    .in_valid (s1_valid_q),
    .in_a     (s1_a_q),
    .in_b     (s1_b_q),
    .in_id    (s1_id_q),
    .out_valid(rsp_valid),
    .out_id   (rsp_id),
    .out_data (rsp_data)
  );

  assign busy = s1_valid_q | rsp_valid;

endmodule
